// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: datapath widths, opcode encodings
// and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;
  localparam int IMM_W   = 5;
  localparam int OPC_W   = 3;

  localparam logic [OPC_W-1:0] OPC_NOP  = 3'b000;
  localparam logic [OPC_W-1:0] OPC_JMP  = 3'b100;
  localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_FETCH = 2'd1,
    SEQ_EXEC  = 2'd2,
    SEQ_HALT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: sequential increment (wrapping) or a zero-extended
// jump immediate.
module pc_next_logic #(
  parameter int ADDR_W = 8,
  parameter int IMM_W  = 5
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic              jump,
  output logic [ADDR_W-1:0] next_pc
);

  // Jump targets are never sign-extended, so only the low 2^IMM_W addresses are reachable.
  always_comb begin
    if (jump) begin
      next_pc = {{(ADDR_W-IMM_W){1'b0}}, imm};
    end else begin
      next_pc = pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/sequence controller: owns the PC, runs the instruction-memory
// handshake and hands each instruction to execute until a HALT opcode.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                 INSTR_W  = cpu_pkg::INSTR_W,
  parameter int                 IMM_W    = cpu_pkg::IMM_W,
  parameter logic [OPC_W-1:0]   OPC_HALT = cpu_pkg::OPC_HALT,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               exec_jump,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  nextPc;
  logic [OPC_W-1:0]   fetchedOpc;

  assign fetchedOpc = mem_rdata[INSTR_W-1 -: OPC_W];

  pc_next_logic #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_pc_next (
    .pc      (pc_q),
    .imm     (instr_q[IMM_W-1:0]),
    .jump    (exec_jump),
    .next_pc (nextPc)
  );

  // Each state only listens to its own handshake input; everything else is ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      SEQ_IDLE: begin
        if (start) state_d = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        if (mem_ack) begin
          instr_d = mem_rdata;
          state_d = (fetchedOpc == OPC_HALT) ? SEQ_HALT : SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        if (exec_done) begin
          pc_d    = nextPc;
          state_d = SEQ_FETCH;
        end
      end
      SEQ_HALT: begin
        state_d = SEQ_HALT;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Handshake outputs decode straight from the registered state, so they hold steady during wait states.
  assign mem_req     = (state_q == SEQ_FETCH);
  assign instr_valid = (state_q == SEQ_EXEC);
  assign halted      = (state_q == SEQ_HALT);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: the bench plays both instruction
// memory and execute stage, checking outputs on the falling clock edge.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic       instr_valid;
  logic       exec_done;
  logic       exec_jump;
  logic [7:0] pc;
  logic       halted;

  int total;
  int bad;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .exec_jump   (exec_jump),
    .pc          (pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, then let one rising edge pass.
  task automatic applyStimulus(input logic r, input logic s, input logic ack,
                               input logic [7:0] rdata, input logic done,
                               input logic jmp);
    rst       = r;
    start     = s;
    mem_ack   = ack;
    mem_rdata = rdata;
    exec_done = done;
    exec_jump = jmp;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Full snapshot of the externally visible state.
  task automatic checkAll(input string tag, input logic req, input logic [7:0] addr,
                          input logic vld, input logic [7:0] ins, input logic hlt);
    checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'(req));
    checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
    checkOutput({tag, ".pc"}, 32'(pc), 32'(addr));
    checkOutput({tag, ".instr_valid"}, 32'(instr_valid), 32'(vld));
    checkOutput({tag, ".instr"}, 32'(instr), 32'(ins));
    checkOutput({tag, ".halted"}, 32'(halted), 32'(hlt));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    exec_done = 1'b0; exec_jump = 1'b0;

    // Reset state
    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    checkAll("reset", 0, 8'h00, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 0);
    checkAll("idle_hold", 0, 8'h00, 0, 8'h00, 0);

    // start together with ack in IDLE: only start counts
    applyStimulus(0, 1, 1, 8'h01, 0, 0);
    checkAll("start", 1, 8'h00, 0, 8'h00, 0);

    // Back-to-back sequential instructions, 2 cycles each
    applyStimulus(0, 0, 1, 8'h01, 0, 0);
    checkAll("exec0", 0, 8'h00, 1, 8'h01, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 0);
    checkAll("fetch1", 1, 8'h01, 0, 8'h01, 0);
    applyStimulus(0, 0, 1, 8'h01, 0, 0);
    checkAll("exec1", 0, 8'h01, 1, 8'h01, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 0);
    checkAll("fetch2", 1, 8'h02, 0, 8'h01, 0);

    // Jumps: immediate zero-extended, opcode bits dropped
    applyStimulus(0, 0, 1, 8'h1A, 0, 0);
    checkAll("exec_j1a", 0, 8'h02, 1, 8'h1A, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 1);
    checkAll("jump_1a", 1, 8'h1A, 0, 8'h1A, 0);
    applyStimulus(0, 0, 1, 8'h3F, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 1);
    checkAll("jump_3f", 1, 8'h1F, 0, 8'h3F, 0);

    // Delayed ack with stray exec_done in FETCH
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 8'h77, 1, 1);
      checkAll("ack_wait", 1, 8'h1F, 0, 8'h3F, 0);
    end
    applyStimulus(0, 0, 1, 8'h02, 0, 0);
    checkAll("exec_02", 0, 8'h1F, 1, 8'h02, 0);

    // Delayed done with stray ack in EXEC
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 1, 8'h55, 0, 0);
      checkAll("done_wait", 0, 8'h1F, 1, 8'h02, 0);
    end
    applyStimulus(0, 0, 0, 8'h00, 1, 0);
    checkAll("after_wait", 1, 8'h20, 0, 8'h02, 0);

    // Walk sequentially from 0x20 up to 0xFF
    for (int i = 0; i < 223; i++) begin
      applyStimulus(0, 0, 1, 8'h01, 0, 0);
      applyStimulus(0, 0, 0, 8'h00, 1, 0);
    end
    checkAll("pc_ff", 1, 8'hFF, 0, 8'h01, 0);
    applyStimulus(0, 0, 1, 8'h01, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 0);
    checkAll("wrap", 1, 8'h00, 0, 8'h01, 0);
    applyStimulus(0, 0, 1, 8'h05, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 0);
    checkAll("pc_01", 1, 8'h01, 0, 8'h05, 0);

    // HALT fetch parks the core with pc unchanged
    applyStimulus(0, 0, 1, 8'hE0, 0, 0);
    checkAll("halt", 0, 8'h01, 0, 8'hE0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 8'h01, 1, 1);
      checkAll("halt_sticky", 0, 8'h01, 0, 8'hE0, 1);
    end
    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    checkAll("halt_reset", 0, 8'h00, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 8'h00, 0, 0);
    checkAll("restart", 1, 8'h00, 0, 8'h00, 0);

    // Reset wins over exec_done in EXEC
    applyStimulus(0, 0, 1, 8'h1A, 0, 0);
    checkAll("exec_pre_rst", 0, 8'h00, 1, 8'h1A, 0);
    applyStimulus(1, 1, 1, 8'h01, 1, 1);
    checkAll("rst_in_exec", 0, 8'h00, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 8'h01, 1, 1);
    checkAll("idle_after_rst", 0, 8'h00, 0, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
